// File: rtl/pulse_train_pkg.sv
// Shared definitions for the pulse_train block: FSM state encoding and mode constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pulse_train_pkg;

    // Sequencer phases; encodings are fixed so software and debug views agree.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        HIGH  = 2'd2,
        LOW   = 2'd3
    } state_e;

    // Sequence modes, latched at start.
    localparam logic ONESHOT    = 1'b0;
    localparam logic CONTINUOUS = 1'b1;

endpackage

// File: rtl/pulse_train_len_counter.sv
// Loadable W-bit down-counter that times one sequencer phase and flags when it reaches zero.
// Latency: load or decrement visible one cycle after the posedge; zero flag is decoded from the register.
// Backpressure: none; decrements only while enabled and saturates at zero, so it never wraps.
module len_counter #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: load wins over decrement; hold at zero instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Count register, cleared by reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/pulse_train.sv
// Pulse-train generator: on a rising edge of on, waits delay cycles then emits high/low pulses (burst or continuous).
// Latency: sequence starts at the posedge that samples the rising edge; all outputs are registered.
// Backpressure: none; rising edges of on while a sequence runs are dropped, never queued.
module pulse_train
    import pulse_train_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         on,
    input  logic         mode,
    input  logic [W-1:0] delay,
    input  logic [W-1:0] high_len,
    input  logic [W-1:0] low_len,
    input  logic [W-1:0] count,
    output logic         signal,
    output logic         busy,
    output logic         done
);

    state_e       state_q,  state_d;
    logic         on_dly_q, on_dly_d;     // previous-cycle copy of on, used for edge detection
    logic         mode_q,   mode_d;
    logic [W-1:0] hlen_q,   hlen_d;       // high time minus one (0 means a single cycle)
    logic [W-1:0] llen_q,   llen_d;       // low time minus one
    logic [W-1:0] pulses_q, pulses_d;     // pulses still to emit in one-shot mode
    logic         signal_q, signal_d;
    logic         busy_q,   busy_d;
    logic         done_q,   done_d;

    logic         start;
    logic         more;
    logic         ph_load;
    logic         ph_en;
    logic [W-1:0] ph_load_val;
    logic         ph_zero;
    logic [W-1:0] high_m1;
    logic [W-1:0] low_m1;
    logic [W-1:0] count_n;

    // Phase timer: loaded with (length - 1) on entry to a phase, phase ends when it reads zero.
    len_counter #(.W(W)) u_phase_cnt (
        .clock    (clock),
        .reset    (reset),
        .load     (ph_load),
        .en       (ph_en),
        .load_val (ph_load_val),
        .zero     (ph_zero)
    );

    // Normalise live inputs: zero lengths and a zero count behave as one.
    always_comb begin
        high_m1 = (high_len == '0) ? '0 : high_len - W'(1);
        low_m1  = (low_len  == '0) ? '0 : low_len  - W'(1);
        count_n = (count    == '0) ? W'(1) : count;
    end

    // Next-state, latch capture, phase-timer control and registered-output precompute.
    always_comb begin
        state_d     = state_q;
        on_dly_d    = on;
        mode_d      = mode_q;
        hlen_d      = hlen_q;
        llen_d      = llen_q;
        pulses_d    = pulses_q;
        done_d      = 1'b0;
        ph_load     = 1'b0;
        ph_en       = 1'b0;
        ph_load_val = '0;
        start       = on & ~on_dly_q & (state_q == IDLE);
        // Continuous mode follows the live on level; one-shot mode follows the remaining count.
        more        = (mode_q == CONTINUOUS) ? on : (pulses_q != '0);

        case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d   = mode;
                    hlen_d   = high_m1;
                    llen_d   = low_m1;
                    pulses_d = count_n;
                    ph_load  = 1'b1;
                    if (delay != '0) begin
                        state_d     = DELAY;
                        ph_load_val = delay - W'(1);
                    end else begin
                        state_d     = HIGH;
                        ph_load_val = high_m1;
                    end
                end
            end
            DELAY: begin
                if (ph_zero) begin
                    state_d     = HIGH;
                    ph_load     = 1'b1;
                    ph_load_val = hlen_q;
                end else begin
                    ph_en = 1'b1;
                end
            end
            HIGH: begin
                if (ph_zero) begin
                    state_d     = LOW;
                    ph_load     = 1'b1;
                    ph_load_val = llen_q;
                    if (pulses_q != '0) begin
                        pulses_d = pulses_q - W'(1);
                    end
                end else begin
                    ph_en = 1'b1;
                end
            end
            LOW: begin
                if (ph_zero) begin
                    if (more) begin
                        state_d     = HIGH;
                        ph_load     = 1'b1;
                        ph_load_val = hlen_q;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    ph_en = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with the state register.
        signal_d = (state_d == HIGH);
        busy_d   = (state_d != IDLE);
    end

    // State, latched configuration and output registers; reset aborts any sequence silently.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            on_dly_q <= 1'b0;
            mode_q   <= ONESHOT;
            hlen_q   <= '0;
            llen_q   <= '0;
            pulses_q <= '0;
            signal_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            on_dly_q <= on_dly_d;
            mode_q   <= mode_d;
            hlen_q   <= hlen_d;
            llen_q   <= llen_d;
            pulses_q <= pulses_d;
            signal_q <= signal_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign signal = signal_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_pulse_train.sv
// Directed bench for pulse_train: burst, zero-length, continuous, retrigger, reset-abort and long-count cases.
// Latency: n/a (testbench).
// Backpressure: n/a.
module tb_pulse_train;

    logic       clock;
    logic       reset;
    logic       on;
    logic       mode;
    logic [7:0] delay;
    logic [7:0] high_len;
    logic [7:0] low_len;
    logic [7:0] count;
    logic       signal;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    pulse_train #(.W(8)) dut (
        .clock    (clock),
        .reset    (reset),
        .on       (on),
        .mode     (mode),
        .delay    (delay),
        .high_len (high_len),
        .low_len  (low_len),
        .count    (count),
        .signal   (signal),
        .busy     (busy),
        .done     (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past one posedge and park on the following negedge for sampling/driving.
    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic set_inputs(input logic [7:0] d, input logic [7:0] h, input logic [7:0] l,
                              input logic [7:0] n, input logic m);
        delay    = d;
        high_len = h;
        low_len  = l;
        count    = n;
        mode     = m;
    endtask

    // Sample n cycles after the start edge into bit vectors (bit i = after edge S+i).
    // on is driven from on_sched[i] after sample i; scramble changes all config inputs after sample 0.
    task automatic capture(input int n, input logic [31:0] on_sched, input bit scramble,
                           output logic [31:0] sv, output logic [31:0] bv, output logic [31:0] dv);
        sv = '0;
        bv = '0;
        dv = '0;
        for (int i = 0; i < n; i++) begin
            tick();
            sv[i] = signal;
            bv[i] = busy;
            dv[i] = done;
            on = on_sched[i];
            if (scramble && i == 0) begin
                set_inputs(8'd9, 8'd7, 8'd5, 8'd4, 1'b1);
            end
        end
    endtask

    logic [31:0] sv, bv, dv;
    int          rise_i, fall_i, done_i;
    logic        prev_sig;

    initial begin
        reset = 1'b1;
        on    = 1'b0;
        set_inputs(8'd0, 8'd0, 8'd0, 8'd0, 1'b0);

        // Reset state
        @(negedge clock);
        check("rst_signal", signal, 1'b0);
        check("rst_busy",   busy,   1'b0);
        check("rst_done",   done,   1'b0);
        reset = 1'b0;
        tick();
        check("idle_busy", busy, 1'b0);

        // One-shot burst D=3 H=2 L=1 N=2, inputs scrambled after start
        set_inputs(8'd3, 8'd2, 8'd1, 8'd2, 1'b0);
        on = 1'b1;
        capture(12, 32'hFFFF_FFFF, 1'b1, sv, bv, dv);
        check("burst_signal", sv, 32'h0D8);
        check("burst_busy",   bv, 32'h1FF);
        check("burst_done",   dv, 32'h200);

        // All-zero lengths: single 1-cycle pulse, 1-cycle gap, done after S+2
        on = 1'b0;
        tick();
        tick();
        set_inputs(8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
        on = 1'b1;
        capture(6, 32'hFFFF_FFFF, 1'b0, sv, bv, dv);
        check("zero_signal", sv, 32'h1);
        check("zero_busy",   bv, 32'h3);
        check("zero_done",   dv, 32'h4);

        // Continuous H=4 L=4, on drops during the second HIGH
        on = 1'b0;
        tick();
        set_inputs(8'd0, 8'd4, 8'd4, 8'd0, 1'b1);
        on = 1'b1;
        capture(20, 32'h0000_01FF, 1'b0, sv, bv, dv);
        check("cont_signal", sv, 32'h0F0F);
        check("cont_busy",   bv, 32'hFFFF);
        check("cont_done",   dv, 32'h1_0000);

        // Retrigger attempts during a burst and on the edge that returns to IDLE
        on = 1'b0;
        tick();
        set_inputs(8'd1, 8'd2, 8'd2, 8'd2, 1'b0);
        on = 1'b1;
        capture(14, 32'hFFFF_FF7A, 1'b0, sv, bv, dv);
        check("retrig_signal", sv, 32'h66);
        check("retrig_busy",   bv, 32'h1FF);
        check("retrig_done",   dv, 32'h200);

        // Reset during the second HIGH, then restart with on held high
        on = 1'b0;
        tick();
        set_inputs(8'd3, 8'd2, 8'd1, 8'd2, 1'b0);
        on = 1'b1;
        capture(7, 32'hFFFF_FFFF, 1'b0, sv, bv, dv);
        check("pre_rst_signal", signal, 1'b1);
        reset = 1'b1;
        #1;
        check("abort_signal", signal, 1'b0);
        check("abort_busy",   busy,   1'b0);
        check("abort_done",   done,   1'b0);
        tick();
        check("held_rst_done", done, 1'b0);
        check("held_rst_busy", busy, 1'b0);
        reset = 1'b0;
        capture(12, 32'hFFFF_FFFF, 1'b0, sv, bv, dv);
        check("restart_signal", sv, 32'h0D8);
        check("restart_busy",   bv, 32'h1FF);
        check("restart_done",   dv, 32'h200);

        // Full-scale counts D=255 H=255 L=1 N=1
        on = 1'b0;
        tick();
        set_inputs(8'd255, 8'd255, 8'd1, 8'd1, 1'b0);
        on       = 1'b1;
        rise_i   = -1;
        fall_i   = -1;
        done_i   = -1;
        prev_sig = 1'b0;
        for (int i = 0; i < 600; i++) begin
            tick();
            if (signal && !prev_sig && rise_i < 0) rise_i = i;
            if (!signal && prev_sig && fall_i < 0) fall_i = i;
            if (done && done_i < 0) done_i = i;
            prev_sig = signal;
        end
        check("long_rise",  rise_i, 32'd255);
        check("long_fall",  fall_i, 32'd510);
        check("long_done",  done_i, 32'd511);
        check("long_idle",  busy,   1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
